// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op encoding, state enum and op-class helpers for muldiv_hilo
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FIXUP = 2'd2
  } state_e;

  function automatic logic is_iter_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// rtl/muldiv_negate.sv - combinational conditional two's-complement negate
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = en ? (~din + W'(1)) : din;

endmodule

// File: rtl/muldiv_hilo.sv
// rtl/muldiv_hilo.sv - iterative radix-2 mul/div unit owning the HI/LO register pair
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_e state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               q_neg;
  logic               r_neg;
  logic [WIDTH-1:0]   a_raw;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               accept_iter, accept_mt;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign a_neg = is_signed_op(op) && a[WIDTH-1];
  assign b_neg = is_signed_op(op) && b[WIDTH-1];

  // A same-cycle flush always beats a start, including MTHI/MTLO.
  assign accept_iter = start && !flush && (state == IDLE) && is_iter_op(op);
  assign accept_mt   = start && !flush && (state == IDLE) && ((op == OP_MTHI) || (op == OP_MTLO));

  muldiv_negate #(.W(WIDTH)) u_neg_a (.en(a_neg), .din(a), .dout(a_mag));
  muldiv_negate #(.W(WIDTH)) u_neg_b (.en(b_neg), .din(b), .dout(b_mag));

  muldiv_negate #(.W(2*WIDTH)) u_neg_prod (.en(q_neg), .din(acc), .dout(prod_fix));
  muldiv_negate #(.W(WIDTH)) u_neg_quo (.en(q_neg), .din(acc[WIDTH-1:0]), .dout(quo_fix));
  muldiv_negate #(.W(WIDTH)) u_neg_rem (.en(r_neg), .din(rem), .dout(rem_fix));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_iter) state_nxt = ITER;
      ITER:    if (flush) state_nxt = IDLE;
               else if (cnt == LAST_STEP) state_nxt = FIXUP;
      FIXUP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // One radix-2 step: multiply adds into the upper half then shifts right;
  // divide shifts the next dividend bit into the remainder and trial-subtracts.
  always_comb begin
    addend  = acc[0] ? opnd : '0;
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    shifted = {rem, acc[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      is_div <= 1'b0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      a_raw  <= '0;
      opnd   <= '0;
      acc    <= '0;
      rem    <= '0;
    end else if (accept_iter) begin
      cnt    <= '0;
      is_div <= is_div_op(op);
      q_neg  <= a_neg ^ b_neg;
      r_neg  <= a_neg;
      a_raw  <= a;
      rem    <= '0;
      if (is_div_op(op)) begin
        acc  <= {{WIDTH{1'b0}}, a_mag};
        opnd <= b_mag;
      end else begin
        acc  <= {{WIDTH{1'b0}}, b_mag};
        opnd <= a_mag;
      end
    end else if (state == ITER) begin
      cnt <= cnt + CNT_W'(1);
      if (is_div) begin
        if (!diff[WIDTH]) begin
          rem            <= diff[WIDTH-1:0];
          acc[WIDTH-1:0] <= {acc[WIDTH-2:0], 1'b1};
        end else begin
          rem            <= shifted[WIDTH-1:0];
          acc[WIDTH-1:0] <= {acc[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc <= {sum, acc[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_by_zero <= 1'b0;
    end else if (accept_iter || accept_mt) begin
      div_by_zero <= is_div_op(op) && (b == '0);
    end
  end

  // MIN / -1 needs no special case: the magnitude quotient is already MIN
  // and the quotient sign is positive, so it passes through unnegated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
    end else if (accept_mt) begin
      if (op == OP_MTHI) hi <= a;
      else               lo <= a;
    end else if ((state == FIXUP) && !flush) begin
      if (!is_div) begin
        hi <= prod_fix[2*WIDTH-1:WIDTH];
        lo <= prod_fix[WIDTH-1:0];
      end else if (div_by_zero) begin
        hi <= a_raw;
        lo <= '1;
      end else begin
        hi <= rem_fix;
        lo <= quo_fix;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done <= 1'b0;
    end else begin
      done <= (state == FIXUP) && !flush;
    end
  end

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb/tb_muldiv_hilo.sv - self-checking bench for muldiv_hilo against a behavioural HI/LO model
module tb_muldiv_hilo;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         flush = 1'b0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int errors = 0;
  int checks = 0;

  muldiv_hilo #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Behavioural model: an accepted mul/div keeps the unit busy for W+1 edges,
  // then the precomputed result lands in HI/LO and done pulses for one cycle.
  int           m_cnt = 0;
  logic         m_done = 1'b0;
  logic         m_dbz = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0;
  logic [W-1:0] p_hi = '0, p_lo = '0;

  function automatic void ref_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] rh, output logic [W-1:0] rl, output logic rz);
    logic [63:0] p;
    rh = '0; rl = '0; rz = 1'b0; p = '0;
    case (o)
      3'd0: begin
        p = longint'($signed(x)) * longint'($signed(y));
        rh = p[63:32]; rl = p[31:0];
      end
      3'd1: begin
        p = {32'b0, x} * {32'b0, y};
        rh = p[63:32]; rl = p[31:0];
      end
      3'd2: begin
        if (y == 0) begin rl = '1; rh = x; rz = 1'b1; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin rl = x; rh = '0; end
        else begin rl = 32'($signed(x) / $signed(y)); rh = 32'($signed(x) % $signed(y)); end
      end
      3'd3: begin
        if (y == 0) begin rl = '1; rh = x; rz = 1'b1; end
        else begin rl = x / y; rh = x % y; end
      end
      default: ;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt = 0; m_done = 1'b0; m_dbz = 1'b0; m_hi = '0; m_lo = '0;
    end else begin
      m_done = 1'b0;
      if (m_cnt > 0) begin
        if (flush) m_cnt = 0;
        else begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) begin m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; end
        end
      end else if (start && !flush) begin
        if (op <= 3'd3) begin
          ref_op(op, a, b, p_hi, p_lo, m_dbz);
          m_cnt = W + 1;
        end else if (op == 3'd4) begin
          m_hi = a; m_dbz = 1'b0;
        end else if (op == 3'd5) begin
          m_lo = a; m_dbz = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    check("busy", 64'(busy), 64'(m_cnt > 0));
    check("done", 64'(done), 64'(m_done));
    check("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
    check("hi", 64'(hi), 64'(m_hi));
    check("lo", 64'(lo), 64'(m_lo));
  endtask

  task automatic drive(input logic s, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input logic f);
    start = s; op = o; a = x; b = y; flush = f;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int nbusy, output int ndone);
    nbusy = 0; ndone = 0;
    drive(1'b1, o, x, y, 1'b0);
    step();
    drive(1'b0, 3'd0, '0, '0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if (busy) nbusy++;
      if (done) ndone++;
      step();
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  int nb, nd;

  initial begin
    drive(1'b0, 3'd0, '0, '0, 1'b0);
    step(); step();
    rst = 1'b1;
    step();
    check("reset_hi", 64'(hi), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb, nd);
    check("multu_busy_cycles", 64'(nb), 64'd33);
    check("multu_done_pulses", 64'(nd), 64'd1);
    check("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    check("multu_lo", 64'(lo), 64'h0000_0001);

    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, nb, nd);
    check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo), 64'hFFFF_FFEB);

    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, nb, nd);
    check("div_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(hi), 64'hFFFF_FFFF);

    run_op(3'd3, 32'd5, 32'd0, nb, nd);
    check("divu0_lo", 64'(lo), 64'hFFFF_FFFF);
    check("divu0_hi", 64'(hi), 64'd5);
    check("divu0_dbz", 64'(div_by_zero), 64'd1);

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, nb, nd);
    check("ovf_lo", 64'(lo), 64'h8000_0000);
    check("ovf_hi", 64'(hi), 64'h0);
    check("ovf_dbz", 64'(div_by_zero), 64'd0);

    drive(1'b1, 3'd4, 32'hA, '0, 1'b0); step();
    drive(1'b1, 3'd5, 32'hB, '0, 1'b0); step();
    check("mt_hi", 64'(hi), 64'hA);
    check("mt_lo", 64'(lo), 64'hB);

    // Flush in cycle 10 of a DIVU: nothing written, no done afterwards.
    drive(1'b1, 3'd3, 32'd100, 32'd3, 1'b0); step();
    drive(1'b0, 3'd0, '0, '0, 1'b0);
    repeat (9) step();
    drive(1'b0, 3'd0, '0, '0, 1'b1); step();
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_hi", 64'(hi), 64'hA);
    check("flush_lo", 64'(lo), 64'hB);
    drive(1'b0, 3'd0, '0, '0, 1'b0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) nd++;
      step();
    end
    check("flush_no_done", 64'(nd), 64'd0);

    // MTHI while busy must be ignored.
    drive(1'b1, 3'd3, 32'd100, 32'd3, 1'b0); step();
    drive(1'b1, 3'd4, 32'd5, '0, 1'b0); step();
    check("busy_mthi_hi", 64'(hi), 64'hA);
    drive(1'b0, 3'd0, '0, '0, 1'b0);
    repeat (40) step();
    check("divu_hi", 64'(hi), 64'd1);
    check("divu_lo", 64'(lo), 64'd33);

    // Reset mid-operation clears state immediately.
    drive(1'b1, 3'd4, 32'hA, '0, 1'b0); step();
    drive(1'b1, 3'd5, 32'hB, '0, 1'b0); step();
    drive(1'b1, 3'd3, 32'd100, 32'd3, 1'b0); step();
    drive(1'b0, 3'd0, '0, '0, 1'b0);
    repeat (9) step();
    #2 rst = 1'b0;
    #1;
    check("rst_mid_hi", 64'(hi), 64'h0);
    check("rst_mid_lo", 64'(lo), 64'h0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    step(); step();
    rst = 1'b1;
    step();

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), pick(), pick(),
            $urandom_range(0, 199) == 0);
      step();
    end
    drive(1'b0, 3'd0, '0, '0, 1'b0);
    repeat (40) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo.md
# muldiv_hilo

Parametrised iterative multiply/divide unit owning the HI/LO register pair for the MIPS core. It executes MULT, MULTU, DIV and DIVU over multiple cycles, and MTHI/MTLO in a single cycle. It presents a start/busy/done handshake so the core stalls on MFHI/MFLO or on a new mul/div op while busy. A flush input aborts an in-flight operation when the core takes an exception.

## Interface
- `WIDTH`, default 32: operand and HI/LO width. Must be even and ≥ 4.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  op request; sampled only when `busy`=0
- `op`  in  3  operation code, values from `muldiv_pkg`
- `a`  in  WIDTH  rs operand
- `b`  in  WIDTH  rt operand
- `flush`  in  1  abort the in-flight op; HI/LO are left unchanged
- `busy`  out  1  an iterative op is in progress
- `done`  out  1  one-cycle pulse; HI/LO were updated on the preceding edge
- `div_by_zero`  out  1  sticky per op; set when DIV/DIVU is accepted with `b`=0; cleared by the next accepted start
- `hi`  out  WIDTH  HI register
- `lo`  out  WIDTH  LO register

## Operation
- States are IDLE, ITER and FIXUP.
- From IDLE, `start` with MULT, MULTU, DIV or DIVU latches operands and moves to ITER.
- For signed ops, operands are latched as magnitudes, and the sign flags are recorded: quotient/product sign = a[MSB]^b[MSB]; remainder sign = a[MSB].
- In ITER, the unit performs one radix-2 step per cycle for WIDTH cycles, counted by a $clog2(WIDTH)+1-bit counter.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring divide with a WIDTH+1-bit partial remainder.
- In FIXUP, results are conditionally negated and written: HI = product[2W-1:W] or remainder; LO = product[W-1:0] or quotient. The state then returns to IDLE.
- MTHI/MTLO with `start` in IDLE write `a` to HI or LO on that edge. They do not assert `busy` or `done`.
- `start` while `busy`=1 is ignored for every op, including MTHI/MTLO. The core guarantees a stall.
- Unknown `op` with `start` is ignored, and the unit stays in IDLE.
- Divide by zero: the unit still runs the full latency. LO = all ones and HI = dividend (`a`, the raw value). `div_by_zero` is set.
- Signed overflow (DIV of MIN by −1): LO = MIN, HI = 0.
- `flush` in ITER or FIXUP returns the unit to IDLE on the next edge. No HI/LO write occurs and `done` stays 0.
- If `flush` and `start` arrive in the same IDLE cycle, `flush` wins and the start is dropped.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `div_by_zero`=0, `hi`=0, `lo`=0. All internal accumulators and the counter are cleared.
- Let the start edge be E0.
  - `busy`=1 after E0.
  - Iteration steps occur at E1 through E_W.
  - FIXUP occurs at E_{W+1}; HI/LO are written and `busy` falls.
  - `done`=1 for exactly the cycle after E_{W+1}.
- Result latency is W+1 cycles from the start edge; the 32-bit result is visible 33 cycles later.
- The earliest back-to-back start is in the `done` cycle.
- MTHI/MTLO: HI/LO are visible the cycle after E0.
- Asserting reset mid-operation forces the reset values immediately; the operation is lost.

## Structure
- `muldiv_pkg` holds:
  - the op encoding: MULT=3'd0, MULTU=3'd1, DIV=3'd2, DIVU=3'd3, MTHI=3'd4, MTLO=3'd5; 6 and 7 are reserved;
  - the state enum: IDLE, ITER, FIXUP.
- One sub-module, `muldiv_negate`: a combinational conditional two's-complement on a parametrised width. It is instantiated for operand magnitude (WIDTH) and for result fixup (2·WIDTH product, WIDTH quotient and remainder).

## Test plan
All scenarios use WIDTH=32.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 33 cycles, HI=0xFFFFFFFE, LO=0x00000001; `done` pulses once and `busy` is high for exactly 33 cycles.
- MULT −3 × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 5 / 0 → LO=0xFFFFFFFF, HI=5, `div_by_zero`=1.
- DIV 0x80000000 / −1 → LO=0x80000000, HI=0, `div_by_zero`=0.
- Preload HI/LO with MTHI 0xA / MTLO 0xB.
  - Start DIVU 100/3 and `flush` in cycle 10 → `busy`=0 next cycle, HI=0xA, LO=0xB, no `done`.
  - Repeat, but assert reset in cycle 10 instead → HI=LO=0 and `busy`=0 immediately.
  - A `start` while `busy` (MTHI 0x5) → HI is unchanged.
